// File: rtl/cpu_result_checker.sv
// Multi-channel result checker for the single-cycle CPU harness: shadows selected
// register-file writes, detects halt (PC self-loop) or timeout, then compares.
module cpu_result_checker #(
  parameter int WIDTH   = 32,
  parameter int NCHK    = 4,
  parameter int AW      = 5,
  parameter int TIMEOUT = 5000,
  parameter int STABLE  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      pc,
  input  logic                  rf_we,
  input  logic [AW-1:0]         rf_waddr,
  input  logic [WIDTH-1:0]      rf_wdata,
  input  logic [NCHK-1:0]       chk_en,
  input  logic [NCHK*AW-1:0]    chk_addr,
  input  logic [NCHK*WIDTH-1:0] chk_exp,
  output logic                  busy,
  output logic                  done,
  output logic                  passed,
  output logic                  timed_out,
  output logic [NCHK-1:0]       fail_mask,
  output logic [WIDTH-1:0]      cycles
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  localparam int SW = $clog2(STABLE + 1);
  localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE - 1);
  localparam logic [WIDTH-1:0] CYC_LAST  = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] CYC_MAX   = WIDTH'(TIMEOUT);

  state_t           state, state_next;
  logic [WIDTH-1:0] shadow [NCHK];
  logic [NCHK-1:0]  valid;
  logic [WIDTH-1:0] pc_prev;
  logic [SW-1:0]    stab;
  logic             pc_same, halt, timeout, enter_run;
  logic [NCHK-1:0]  fail_next;

  // cycles==0 marks the first RUN cycle, where pc_prev is still stale.
  assign pc_same   = (cycles != '0) && (pc == pc_prev);
  assign halt      = (state == RUN) && pc_same && (stab >= STAB_LAST);
  assign timeout   = (state == RUN) && (cycles == CYC_LAST);
  assign enter_run = ((state == IDLE) || (state == DONE)) && start;

  assign busy = (state == RUN) || (state == CHECK);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (halt || timeout) state_next = CHECK;
      CHECK:   state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Address-0 channels are treated as always written with value 0.
  always_comb begin
    fail_next = '0;
    for (int unsigned i = 0; i < NCHK; i++) begin
      if (chk_addr[i*AW +: AW] == '0)
        fail_next[i] = chk_en[i] & (chk_exp[i*WIDTH +: WIDTH] != '0);
      else
        fail_next[i] = chk_en[i] & (~valid[i] | (shadow[i] != chk_exp[i*WIDTH +: WIDTH]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset || enter_run) begin
      for (int unsigned i = 0; i < NCHK; i++) shadow[i] <= '0;
      valid     <= '0;
      pc_prev   <= '0;
      stab      <= '0;
      cycles    <= '0;
      timed_out <= 1'b0;
      fail_mask <= '0;
      passed    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          for (int unsigned i = 0; i < NCHK; i++) begin
            if (rf_we && (rf_waddr != '0) && (rf_waddr == chk_addr[i*AW +: AW])) begin
              shadow[i] <= rf_wdata;
              valid[i]  <= 1'b1;
            end
          end
          pc_prev <= pc;
          stab    <= pc_same ? stab + 1'b1 : '0;
          if (cycles != CYC_MAX) cycles <= cycles + 1'b1;
          if (timeout && !halt) timed_out <= 1'b1;
        end
        CHECK: begin
          fail_mask <= fail_next;
          passed    <= ~|fail_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_result_checker.sv
// Scoreboard bench for cpu_result_checker: a driver plays short CPU traces and a
// monitor compares each completed run against a trace-level reference model.
module tb_cpu_result_checker;

  localparam int WIDTH   = 32;
  localparam int NCHK    = 4;
  localparam int AW      = 5;
  localparam int TIMEOUT = 20;
  localparam int STABLE  = 4;
  localparam int PLEN    = 40;

  logic                  clk = 1'b0;
  logic                  reset, start;
  logic [WIDTH-1:0]      pc;
  logic                  rf_we;
  logic [AW-1:0]         rf_waddr;
  logic [WIDTH-1:0]      rf_wdata;
  logic [NCHK-1:0]       chk_en;
  logic [NCHK*AW-1:0]    chk_addr;
  logic [NCHK*WIDTH-1:0] chk_exp;
  logic                  busy, done, passed, timed_out;
  logic [NCHK-1:0]       fail_mask;
  logic [WIDTH-1:0]      cycles;

  cpu_result_checker #(
    .WIDTH(WIDTH), .NCHK(NCHK), .AW(AW), .TIMEOUT(TIMEOUT), .STABLE(STABLE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .chk_en(chk_en),
    .chk_addr(chk_addr), .chk_exp(chk_exp), .busy(busy), .done(done),
    .passed(passed), .timed_out(timed_out), .fail_mask(fail_mask), .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            passed;
    logic            timed_out;
    logic [NCHK-1:0] mask;
    int unsigned     cyc;
    int unsigned     lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Trace: index t is the input presented on the t-th RUN edge (t >= 1).
  logic [WIDTH-1:0] p_pc [PLEN];
  logic             p_we [PLEN];
  logic [AW-1:0]    p_wa [PLEN];
  logic [WIDTH-1:0] p_wd [PLEN];
  logic             c_en   [NCHK];
  logic [AW-1:0]    c_addr [NCHK];
  logic [WIDTH-1:0] c_exp  [NCHK];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic new_prog(input int unsigned k, input logic [WIDTH-1:0] base);
    for (int t = 0; t < PLEN; t++) begin
      p_pc[t] = base + WIDTH'(4 * ((t < int'(k)) ? t : int'(k) - 1));
      p_we[t] = 1'b0;
      p_wa[t] = '0;
      p_wd[t] = '0;
    end
  endtask

  task automatic add_wr(input int t, input int unsigned a, input int unsigned d);
    p_we[t] = 1'b1;
    p_wa[t] = AW'(a);
    p_wd[t] = WIDTH'(d);
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < NCHK; i++) begin
      c_en[i] = 1'b0; c_addr[i] = '0; c_exp[i] = '0;
    end
  endtask

  task automatic set_ch(input int i, input int unsigned a, input int unsigned e);
    c_en[i] = 1'b1; c_addr[i] = AW'(a); c_exp[i] = WIDTH'(e);
  endtask

  // Run ends at the first edge j closing a window of STABLE+1 equal PCs, else at TIMEOUT.
  task automatic find_end(output int unsigned e, output logic halted);
    logic same;
    halted = 1'b0;
    e = TIMEOUT;
    for (int j = STABLE + 1; j <= TIMEOUT; j++) begin
      if (!halted) begin
        same = 1'b1;
        for (int m = j - STABLE + 1; m <= j; m++)
          if (p_pc[m] != p_pc[m-1]) same = 1'b0;
        if (same) begin halted = 1'b1; e = j; end
      end
    end
  endtask

  task automatic final_reg(input logic [AW-1:0] a, input int unsigned e,
                           output logic wr, output logic [WIDTH-1:0] v);
    wr = (a == '0);
    v  = '0;
    if (a != '0)
      for (int t = 1; t <= int'(e); t++)
        if (p_we[t] && p_wa[t] == a) begin wr = 1'b1; v = p_wd[t]; end
  endtask

  task automatic predict();
    exp_t x;
    int unsigned e;
    logic halted, wr;
    logic [WIDTH-1:0] v;
    find_end(e, halted);
    x.mask = '0;
    for (int i = 0; i < NCHK; i++) begin
      final_reg(c_addr[i], e, wr, v);
      x.mask[i] = c_en[i] & (!wr || v != c_exp[i]);
    end
    x.passed    = (x.mask == '0);
    x.timed_out = !halted;
    x.cyc       = e;
    x.lat       = e + 1;
    sb.push_back(x);
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NCHK; i++) begin
      chk_en[i]                = c_en[i];
      chk_addr[i*AW +: AW]     = c_addr[i];
      chk_exp[i*WIDTH +: WIDTH] = c_exp[i];
    end
  endtask

  task automatic drive(input int t);
    int idx;
    idx      = (t < PLEN) ? t : PLEN - 1;
    pc       = p_pc[idx];
    rf_we    = p_we[idx];
    rf_waddr = p_wa[idx];
    rf_wdata = p_wd[idx];
  endtask

  task automatic begin_run();
    apply_cfg();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on_start", busy, 1);
    chk("clear_passed", passed, 0);
    chk("clear_timed_out", timed_out, 0);
    chk("clear_fail_mask", fail_mask, 0);
    chk("clear_cycles", cycles, 0);
    drive(1);
  endtask

  task automatic run();
    logic got;
    predict();
    begin_run();
    got = 1'b0;
    for (int t = 2; t < 80 && !got; t++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else drive(t);
    end
    rf_we = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_wait: got no done expected done within 80 cycles");
      void'(sb.pop_back());
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  // Monitor: latency counts negedges since busy rose; compares on done's rising edge.
  initial begin
    int unsigned lat = 0;
    logic bq = 1'b0, dq = 1'b0;
    exp_t x;
    forever begin
      @(negedge clk);
      if (busy && !bq) lat = 0;
      else lat++;
      if (done && !dq) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          x = sb.pop_front();
          chk("passed", passed, x.passed);
          chk("timed_out", timed_out, x.timed_out);
          chk("fail_mask", fail_mask, x.mask);
          chk("cycles", cycles, x.cyc);
          chk("done_latency", lat, x.lat);
        end
      end
      bq = busy;
      dq = done;
    end
  end

  initial begin
    logic wr;
    logic [WIDTH-1:0] v;
    int unsigned e;
    logic halted;

    reset = 1'b1; start = 1'b0; pc = '0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    chk_en = '0; chk_addr = '0; chk_exp = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_passed", passed, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_fail_mask", fail_mask, 0);
    chk("rst_cycles", cycles, 0);
    reset = 1'b0;

    // Hanoi-style: reg2=270 then self-loop.
    clear_cfg(); set_ch(0, 2, 270);
    new_prog(8, 32'h100); add_wr(3, 2, 270); add_wr(5, 5, 1);
    run();

    // Three channels, third value wrong.
    clear_cfg(); set_ch(0, 2, 58); set_ch(1, 8, 119); set_ch(2, 11, 42);
    new_prog(10, 0); add_wr(2, 2, 58); add_wr(4, 8, 119); add_wr(6, 11, 41);
    run();

    // Never-written channel fails; on reg0 it passes.
    clear_cfg(); set_ch(0, 2, 58); set_ch(3, 9, 0);
    new_prog(6, 0); add_wr(2, 2, 58);
    run();
    clear_cfg(); set_ch(0, 2, 58); set_ch(3, 0, 0);
    add_wr(3, 0, 7);
    run();

    // Timeout: PC never repeats.
    clear_cfg(); set_ch(1, 4, 3);
    new_prog(PLEN + 5, 32'h40); add_wr(2, 4, 3);
    run();

    // Overwrite with the last write on the halt-declaring edge (k=4 -> edge 7).
    clear_cfg(); set_ch(0, 2, 4);
    new_prog(4, 0); add_wr(6, 2, 5); add_wr(7, 2, 4);
    run();

    // Halt exactly on the timeout edge, then one edge too late.
    clear_cfg(); set_ch(0, 3, 9);
    new_prog(17, 0); add_wr(20, 3, 9);
    run();
    new_prog(18, 0); add_wr(20, 3, 9);
    run();

    // No channel enabled.
    clear_cfg(); c_addr[1] = 5'd6; c_exp[1] = 32'd99;
    new_prog(5, 0); add_wr(2, 6, 1);
    run();

    // Reset at RUN edge 7, then a run that never writes reg2.
    clear_cfg(); set_ch(0, 2, 33);
    new_prog(15, 0); add_wr(3, 2, 33);
    begin_run();
    for (int t = 2; t <= 7; t++) begin
      @(negedge clk);
      drive(t);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_passed", passed, 0);
    chk("midrst_timed_out", timed_out, 0);
    chk("midrst_fail_mask", fail_mask, 0);
    chk("midrst_cycles", cycles, 0);
    new_prog(6, 0); add_wr(2, 7, 33);
    run();

    // Randomized traces, back to back from DONE.
    for (int n = 0; n < 40; n++) begin
      p_pc[0] = $urandom & ~32'h3;
      p_we[0] = 1'b0; p_wa[0] = '0; p_wd[0] = '0;
      e = $urandom_range(2, 26);
      for (int t = 1; t < PLEN; t++) begin
        if (t < int'(e)) p_pc[t] = p_pc[t-1] + (($urandom_range(0, 4) == 0) ? 32'd0 : 32'd4);
        else             p_pc[t] = p_pc[t-1];
        p_we[t] = 1'($urandom_range(0, 1));
        p_wa[t] = AW'($urandom_range(0, 11));
        p_wd[t] = WIDTH'($urandom_range(0, 7));
      end
      find_end(e, halted);
      for (int i = 0; i < NCHK; i++) begin
        c_en[i]   = 1'($urandom_range(0, 1));
        c_addr[i] = AW'($urandom_range(0, 11));
        final_reg(c_addr[i], e, wr, v);
        c_exp[i]  = ($urandom_range(0, 1) == 1) ? v : WIDTH'($urandom_range(0, 7));
      end
      run();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
